// File: rtl/countdown_timer_if.sv
// Control and display bundle shared by the countdown timer and its driver.
// The master drives load/start/stop and the preset; the slave returns the count and status.
interface countdown_timer_if;
  logic       load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       done;
  logic       done_pulse;

  modport master (
    output load, load_min, load_sec, start, stop,
    input  minutes, seconds, running, done, done_pulse
  );

  modport slave (
    input  load, load_min, load_sec, start, stop,
    output minutes, seconds, running, done, done_pulse
  );
endinterface

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with a prescaled one-second tick and a registered expiry flag.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN reloads the saved preset on expiry instead of stopping.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned PRE_W    = 16
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_PAUSED,
    S_EXPIRED
  } state_e;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [6:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       preset_min_q, preset_min_d;
  logic [5:0]       preset_sec_q, preset_sec_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             done_pulse_q, done_pulse_d;

  logic [6:0] clamp_min;
  logic [5:0] clamp_sec;
  logic       count_zero;
  logic       tick;
  logic       expiring;

  assign clamp_min  = (bus.load_min > 7'd99) ? 7'd99 : bus.load_min;
  assign clamp_sec  = (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;
  assign count_zero = (min_q == 7'd0) && (sec_q == 6'd0);
  assign tick       = (pre_q == PRE_LAST);
  // RUNNING never holds 00:00, so 00:01 is the only value a tick can take to zero.
  assign expiring   = tick && (min_q == 7'd0) && (sec_q == 6'd1);

  // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    min_d        = min_q;
    sec_d        = sec_q;
    pre_d        = pre_q;
    preset_min_d = preset_min_q;
    preset_sec_d = preset_sec_q;
    done_pulse_d = 1'b0;

    if (bus.load && (state_q != S_RUNNING)) begin
      min_d        = clamp_min;
      sec_d        = clamp_sec;
      preset_min_d = clamp_min;
      preset_sec_d = clamp_sec;
      pre_d        = '0;
      state_d      = S_IDLE;
    end else if (bus.stop && (state_q == S_RUNNING)) begin
      state_d = S_PAUSED;
    end else if (bus.start && ((state_q == S_IDLE) || (state_q == S_PAUSED)) && !count_zero) begin
      state_d = S_RUNNING;
    end else if (state_q == S_RUNNING) begin
      if (tick) begin
        pre_d = '0;
        if (sec_q != 6'd0) begin
          sec_d = sec_q - 6'd1;
        end else if (min_q != 7'd0) begin
          sec_d = 6'd59;
          min_d = min_q - 7'd1;
        end
        if (expiring) begin
          done_pulse_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if ((preset_min_q != 7'd0) || (preset_sec_q != 6'd0)) begin
            min_d = preset_min_q;
            sec_d = preset_sec_q;
          end else begin
            state_d = S_EXPIRED;
          end
`else
          state_d = S_EXPIRED;
`endif
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    running_d = (state_d == S_RUNNING);
    done_d    = (state_d == S_EXPIRED);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      min_q        <= '0;
      sec_q        <= '0;
      pre_q        <= '0;
      preset_min_q <= '0;
      preset_sec_q <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      pre_q        <= pre_d;
      preset_min_q <= preset_min_d;
      preset_sec_q <= preset_sec_d;
      running_q    <= running_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bus.minutes    = min_q;
  assign bus.seconds    = sec_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.done_pulse = done_pulse_q;

endmodule
